restart_cause_monitor: RTL and testbench
========================================

# restart_cause_monitor

Latches the alarm monitor outputs of the alarm module (A13) into a sticky restart-cause register, presented as a channel-77-style read/clear port. Converts A13's RESTRT level into a fixed-width GOJAM pulse and drives a RESTART lamp held until DSKY error reset. It also keeps a saturating restart count. The block sits directly downstream of A13 and feeds the channel read mux and the DSKY lamp driver.

## Interface

Parameters:
- GOJAM_LEN, 4: width of the GOJAM pulse in clocks (legal range 1–15).

Ports:
- clk  in  1  system clock. All state updates occur on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- ALM_  in  8  A13 monitor alarms, active-low:
  - [0] MTCAL_
  - [1] MRPTAL_
  - [2] MCTRAL_
  - [3] MSCAFL_
  - [4] MVFAIL_
  - [5] MOSCAL_
  - [6] MPIPAL_
  - [7] MWARNF_
- SCADBL  in  1  scaler-double alarm, active-high.
- RESTRT  in  1  restart request level from A13.
- ERRST  in  1  DSKY error reset. Clears the lamp.
- CHRD  in  1  channel read strobe, one cycle.
- CHWR  in  1  channel write strobe, one cycle.
- CHWD  in  15  write data, used as a clear mask.
- CHRDAT  out  15  read data. Equals 0 whenever CHVLD=0.
- CHVLD  out  1  read data valid.
- GOJAM  out  1  restart pulse.
- RSTLMP  out  1  RESTART lamp.
- RSTCNT  out  4  saturating restart count.

## Operation

- Input stage:
  - ALM_, SCADBL and RESTRT are registered each cycle into a sample register.
  - A prev register holds the prior sample.
  - On reset, prev ALM_ = 8'hFF, prev SCADBL = 0, prev RESTRT = 0.
- Cause register CAUSE[8:0], sticky:
  - CAUSE[i] (i = 0..7) sets on a 1→0 transition between prev and sample of ALM_[i].
  - CAUSE[8] sets on a 0→1 transition of SCADBL.
  - A held alarm sets its bit once. The bit does not re-set until the input deasserts and reasserts.
- Clear by write:
  - On CHWR, CAUSE[i] clears where CHWD[i] = 1 (i = 0..8).
  - CHWD[14] = 1 also clears RSTCNT.
  - CHWD[13:9] are ignored.
  - If a set and a clear of the same bit occur in the same cycle, the set wins.
- Read:
  - CHRD in cycle k captures {6'b0, CAUSE} as it stood before any clear in cycle k.
  - That value is presented on CHRDAT with CHVLD = 1 in cycle k+1 only.
  - If CHRD and CHWR coincide, the read returns the pre-clear value.
- Restart FSM, states IDLE, JAM, HOLD:
  - IDLE → JAM on a 0→1 edge of RESTRT between prev and sample. On this transition RSTLMP sets and RSTCNT increments, saturating at 15.
  - JAM: GOJAM = 1 for exactly GOJAM_LEN cycles. RESTRT edges are ignored and the pulse is not extended. Then go to HOLD.
  - HOLD → IDLE when the RESTRT sample is 0. If RESTRT has already dropped, HOLD lasts exactly one cycle.
- Lamp: RSTLMP clears on ERRST only while in IDLE. ERRST in JAM or HOLD is ignored.
- Reset, in any state including mid-JAM: CAUSE = 0, RSTCNT = 0, RSTLMP = 0, GOJAM = 0, CHVLD = 0, CHRDAT = 0, FSM = IDLE. GOJAM is truncated immediately.

## Timing

- Alarm latency: an input change present before edge k is registered at k and reflected in CAUSE after edge k+1.
- Read latency: 1 cycle, from the CHRD cycle to the CHVLD cycle. Back-to-back CHRD gives back-to-back CHVLD.
- GOJAM latency: RESTRT rising before edge k → GOJAM high from after edge k+1 through GOJAM_LEN cycles.
- RSTLMP and RSTCNT update on the same edge that GOJAM rises.
- Write takes effect on the edge of the CHWR cycle. A CHRD one cycle later reads the cleared value.

## Test plan

- Reset, then hold ALM_ = 8'hFF and SCADBL = 0 → all outputs 0. CHRD returns CHRDAT = 0 with CHVLD = 1 one cycle later.
- Drive ALM_[2] low for 10 cycles, then high, then low again; pulse SCADBL → CAUSE = 9'h104 after the first edge, unchanged on reassertion. CHRD → CHRDAT = 15'h0104.
- With CAUSE = 9'h104, write CHWD = 15'h0004 → read 15'h0100. In the same cycle as a fresh MTCAL_ fall, write CHWD = 15'h0001 → bit 0 remains set (set wins).
- With GOJAM_LEN = 4, raise RESTRT for 20 cycles → GOJAM high for exactly 4 cycles starting 2 cycles after the edge, RSTCNT = 1, RSTLMP = 1. ERRST during HOLD is ignored; ERRST after RESTRT drops clears RSTLMP.
- Issue 17 restart pulses → RSTCNT saturates at 15. Write CHWD = 15'h4000 → RSTCNT = 0 with CAUSE unchanged.
- Assert rst during the third cycle of JAM → GOJAM = 0, state IDLE, all outputs 0 on the next edge. A new RESTRT edge then produces a full 4-cycle pulse.

Source files
------------

// File: rtl/restart_cause_monitor.sv
// restart_cause_monitor: sticky restart-cause latch behind the A13 alarm
// monitor. It provides a channel-style read/clear port, shapes RESTRT into
// a fixed-width GOJAM pulse, drives the RESTART lamp and keeps a saturating
// restart count.
//
// Channel port handshake: CHRD and CHWR are single-cycle strobes with no
// back-pressure. A CHRD in cycle k always yields CHVLD=1 in cycle k+1 only,
// and that read carries CAUSE as it stood before any clear in cycle k.
// A CHWR takes effect on the edge that closes its own cycle.
module restart_cause_monitor #(
    parameter int unsigned GOJAM_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ALM_,
    input  logic        SCADBL,
    input  logic        RESTRT,
    input  logic        ERRST,
    input  logic        CHRD,
    input  logic        CHWR,
    input  logic [14:0] CHWD,
    output logic [14:0] CHRDAT,
    output logic        CHVLD,
    output logic        GOJAM,
    output logic        RSTLMP,
    output logic [3:0]  RSTCNT,
    output logic [1:0]  DBG_STATE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_JAM  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Down-counter reload: the pulse is high for JAM_LAST+1 cycles.
    localparam logic [3:0] JAM_LAST = 4'(GOJAM_LEN - 1);

    logic [7:0]  r_alm_s;
    logic [7:0]  r_alm_p;
    logic        r_scad_s;
    logic        r_scad_p;
    logic        r_rst_s;
    logic        r_rst_p;
    logic [8:0]  r_cause;
    logic [14:0] r_chrdat;
    logic        r_chvld;
    state_t      r_state;
    logic [3:0]  r_jam_cnt;
    logic        r_gojam;
    logic        r_rstlmp;
    logic [3:0]  r_rstcnt;

    logic [8:0]  w_set;
    logic [8:0]  w_clr;
    logic        w_restrt_rise;
    logic        w_cnt_inc;
    logic        w_cnt_clr;
    logic [3:0]  w_cnt_base;
    logic [3:0]  w_cnt_next;

    // Edges are taken between the previous and current samples, so a held
    // alarm produces exactly one set event.
    assign w_set         = {~r_scad_p & r_scad_s, r_alm_p & ~r_alm_s};
    assign w_clr         = CHWR ? CHWD[8:0] : 9'd0;
    assign w_restrt_rise = ~r_rst_p & r_rst_s;

    // Restart count: a write clear applies first, so a coincident restart
    // still counts on top of the cleared value.
    assign w_cnt_inc  = (r_state == ST_IDLE) && w_restrt_rise;
    assign w_cnt_clr  = CHWR & CHWD[14];
    assign w_cnt_base = w_cnt_clr ? 4'd0 : r_rstcnt;
    assign w_cnt_next = (w_cnt_inc && (w_cnt_base != 4'hF)) ? w_cnt_base + 4'd1
                                                            : w_cnt_base;

    // Input sample register and the previous-sample register behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alm_s  <= 8'hFF;
            r_alm_p  <= 8'hFF;
            r_scad_s <= 1'b0;
            r_scad_p <= 1'b0;
            r_rst_s  <= 1'b0;
            r_rst_p  <= 1'b0;
        end else begin
            r_alm_s  <= ALM_;
            r_alm_p  <= r_alm_s;
            r_scad_s <= SCADBL;
            r_scad_p <= r_scad_s;
            r_rst_s  <= RESTRT;
            r_rst_p  <= r_rst_s;
        end
    end

    // Sticky cause bits: clear by write mask, a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cause <= 9'd0;
        end else begin
            r_cause <= (r_cause & ~w_clr) | w_set;
        end
    end

    // Read port: capture the pre-clear CAUSE, present it for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chrdat <= 15'd0;
            r_chvld  <= 1'b0;
        end else if (CHRD) begin
            r_chrdat <= {6'd0, r_cause};
            r_chvld  <= 1'b1;
        end else begin
            r_chrdat <= 15'd0;
            r_chvld  <= 1'b0;
        end
    end

    // Restart FSM with registered GOJAM, lamp and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_jam_cnt <= 4'd0;
            r_gojam   <= 1'b0;
            r_rstlmp  <= 1'b0;
            r_rstcnt  <= 4'd0;
        end else begin
            r_rstcnt <= w_cnt_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_restrt_rise) begin
                        r_state   <= ST_JAM;
                        r_jam_cnt <= JAM_LAST;
                        r_gojam   <= 1'b1;
                        r_rstlmp  <= 1'b1;
                    end else if (ERRST) begin
                        r_rstlmp <= 1'b0;
                    end
                end
                ST_JAM: begin
                    if (r_jam_cnt == 4'd0) begin
                        r_state <= ST_HOLD;
                        r_gojam <= 1'b0;
                    end else begin
                        r_jam_cnt <= r_jam_cnt - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (!r_rst_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gojam <= 1'b0;
                end
            endcase
        end
    end

    assign CHRDAT    = r_chrdat;
    assign CHVLD     = r_chvld;
    assign GOJAM     = r_gojam;
    assign RSTLMP    = r_rstlmp;
    assign RSTCNT    = r_rstcnt;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_restart_cause_monitor.sv
// Directed testbench for restart_cause_monitor (GOJAM_LEN = 4).
module tb_restart_cause_monitor;

    logic        clk;
    logic        rst;
    logic [7:0]  ALM_;
    logic        SCADBL;
    logic        RESTRT;
    logic        ERRST;
    logic        CHRD;
    logic        CHWR;
    logic [14:0] CHWD;
    logic [14:0] CHRDAT;
    logic        CHVLD;
    logic        GOJAM;
    logic        RSTLMP;
    logic [3:0]  RSTCNT;
    logic [1:0]  DBG_STATE;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_JAM  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    restart_cause_monitor #(.GOJAM_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ALM_      (ALM_),
        .SCADBL    (SCADBL),
        .RESTRT    (RESTRT),
        .ERRST     (ERRST),
        .CHRD      (CHRD),
        .CHWR      (CHWR),
        .CHWD      (CHWD),
        .CHRDAT    (CHRDAT),
        .CHVLD     (CHVLD),
        .GOJAM     (GOJAM),
        .RSTLMP    (RSTLMP),
        .RSTCNT    (RSTCNT),
        .DBG_STATE (DBG_STATE)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Single read: CHRD for one cycle, data valid the next cycle only.
    task automatic do_read(input string tag, input logic [14:0] exp);
        CHRD = 1'b1;
        tick();
        CHRD = 1'b0;
        chk({tag, "_vld"}, {15'd0, CHVLD}, 16'd1);
        chk({tag, "_dat"}, {1'b0, CHRDAT}, {1'b0, exp});
        tick();
        chk({tag, "_vld_drop"}, {15'd0, CHVLD}, 16'd0);
    endtask

    task automatic do_write(input logic [14:0] mask);
        CHWR = 1'b1;
        CHWD = mask;
        tick();
        CHWR = 1'b0;
        CHWD = 15'd0;
    endtask

    // One short RESTRT pulse and enough cycles to return to IDLE.
    task automatic restart_pulse();
        RESTRT = 1'b1;
        tick();
        RESTRT = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        rst = 1'b1; ALM_ = 8'hFF; SCADBL = 1'b0; RESTRT = 1'b0; ERRST = 1'b0;
        CHRD = 1'b0; CHWR = 1'b0; CHWD = 15'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_gojam",  {15'd0, GOJAM},  16'd0);
        chk("rst_lamp",   {15'd0, RSTLMP}, 16'd0);
        chk("rst_cnt",    {12'd0, RSTCNT}, 16'd0);
        chk("rst_vld",    {15'd0, CHVLD},  16'd0);
        chk("rst_dat",    {1'b0, CHRDAT},  16'd0);
        chk("rst_state",  {14'd0, DBG_STATE}, {14'd0, S_IDLE});
        do_read("rd_idle", 15'h0000);

        // MCTRAL_ falls; a read one edge later still sees the old CAUSE
        ALM_ = 8'hFB;
        tick();
        do_read("rd_latency", 15'h0000);
        do_read("rd_mctral", 15'h0004);
        repeat (6) tick();
        ALM_ = 8'hFF;
        repeat (3) tick();
        ALM_ = 8'hFB;
        repeat (3) tick();
        SCADBL = 1'b1;
        tick();
        SCADBL = 1'b0;
        repeat (2) tick();
        do_read("rd_104", 15'h0104);

        // Clear bit 2 while MCTRAL_ is still held low: it must stay clear
        do_write(15'h0004);
        do_read("rd_after_clr", 15'h0100);

        // Coincident read and write returns the pre-clear value
        CHRD = 1'b1; CHWR = 1'b1; CHWD = 15'h0100;
        tick();
        CHRD = 1'b0; CHWR = 1'b0; CHWD = 15'd0;
        chk("rdwr_vld", {15'd0, CHVLD}, 16'd1);
        chk("rdwr_dat", {1'b0, CHRDAT}, 16'h0100);
        tick();
        do_read("rd_after_rdwr", 15'h0000);

        // Fresh MTCAL_ fall coincident with a clear of bit 0: set wins
        ALM_ = 8'hFA;
        tick();
        do_write(15'h0001);
        do_read("rd_setwins", 15'h0001);
        do_write(15'h01FF);
        do_read("rd_all_clr", 15'h0000);
        ALM_ = 8'hFF;
        repeat (2) tick();

        // Restart: GOJAM rises two edges after the RESTRT edge, 4 cycles wide
        RESTRT = 1'b1;
        tick();
        chk("jam_not_yet", {15'd0, GOJAM}, 16'd0);
        tick();
        chk("jam_state", {14'd0, DBG_STATE}, {14'd0, S_JAM});
        chk("jam_lamp",  {15'd0, RSTLMP}, 16'd1);
        chk("jam_cnt",   {12'd0, RSTCNT}, 16'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("jam_high_%0d", i), {15'd0, GOJAM}, 16'd1);
            tick();
        end
        chk("jam_end",    {15'd0, GOJAM}, 16'd0);
        chk("hold_state", {14'd0, DBG_STATE}, {14'd0, S_HOLD});
        ERRST = 1'b1;
        tick();
        ERRST = 1'b0;
        chk("errst_hold_ignored", {15'd0, RSTLMP}, 16'd1);
        chk("hold_stays", {14'd0, DBG_STATE}, {14'd0, S_HOLD});
        repeat (12) tick();
        RESTRT = 1'b0;
        repeat (2) tick();
        chk("back_idle", {14'd0, DBG_STATE}, {14'd0, S_IDLE});
        chk("lamp_kept", {15'd0, RSTLMP}, 16'd1);
        ERRST = 1'b1;
        tick();
        ERRST = 1'b0;
        chk("lamp_cleared", {15'd0, RSTLMP}, 16'd0);

        // Short pulse: HOLD lasts exactly one cycle
        RESTRT = 1'b1;
        tick();
        RESTRT = 1'b0;
        repeat (5) tick();
        chk("short_hold", {14'd0, DBG_STATE}, {14'd0, S_HOLD});
        tick();
        chk("short_idle", {14'd0, DBG_STATE}, {14'd0, S_IDLE});
        chk("cnt_2", {12'd0, RSTCNT}, 16'd2);
        repeat (2) tick();

        // Saturation of the restart count
        for (int i = 0; i < 12; i++) restart_pulse();
        chk("cnt_14", {12'd0, RSTCNT}, 16'd14);
        for (int i = 0; i < 4; i++) restart_pulse();
        chk("cnt_sat", {12'd0, RSTCNT}, 16'd15);

        // Count clear leaves CAUSE untouched
        ALM_ = 8'h7F;
        repeat (3) tick();
        do_write(15'h4000);
        chk("cnt_clr", {12'd0, RSTCNT}, 16'd0);
        do_read("rd_cause_kept", 15'h0080);
        ALM_ = 8'hFF;
        repeat (2) tick();

        // Reset during the third cycle of JAM
        RESTRT = 1'b1;
        tick();
        tick();
        chk("jam2_start", {15'd0, GOJAM}, 16'd1);
        tick();
        tick();
        rst = 1'b1;
        RESTRT = 1'b0;
        tick();
        chk("midrst_gojam", {15'd0, GOJAM},  16'd0);
        chk("midrst_state", {14'd0, DBG_STATE}, {14'd0, S_IDLE});
        chk("midrst_lamp",  {15'd0, RSTLMP}, 16'd0);
        chk("midrst_cnt",   {12'd0, RSTCNT}, 16'd0);
        chk("midrst_vld",   {15'd0, CHVLD},  16'd0);
        rst = 1'b0;
        tick();
        do_read("rd_midrst", 15'h0000);

        // A new RESTRT edge gives a full 4-cycle pulse
        RESTRT = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("jam3_high_%0d", i), {15'd0, GOJAM}, 16'd1);
            tick();
        end
        chk("jam3_end", {15'd0, GOJAM}, 16'd0);
        chk("jam3_cnt", {12'd0, RSTCNT}, 16'd1);
        RESTRT = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
